instr_stream_encoder: RTL and testbench

INSTR_STREAM_ENCODER -- requirements
Module: instr_stream_encoder

---
 rtl/instr_stream_encoder.sv | 157 +++++++++++++++
 tb/tb_instr_stream_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_encoder.sv
// RV32I instruction stream encoder: turns field-level requests into
// encoded words and writes them to sequential instruction-memory slots.
module instr_stream_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [2:0]        alu_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [11:0]       imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err,
  output logic              done
);

  localparam logic ST_LOADING = 1'b0;
  localparam logic ST_FULL    = 1'b1;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  logic              state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              err_q, err_d;

  logic        alu_ok;
  logic        alu_sub;
  logic [2:0]  alu_f3;
  logic        legal;
  logic [31:0] word;
  logic        fire;

  assign done     = (state_q == ST_FULL);
  assign in_ready = !done && !restart && !rst;
  assign fire     = in_valid && in_ready;

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign err     = err_q;

  // Map the ALUControl code onto funct3 and flag undefined codes.
  always_comb begin
    alu_ok  = 1'b1;
    alu_sub = 1'b0;
    alu_f3  = 3'b000;
    case (alu_sel)
      3'b000: alu_f3 = 3'b000;
      3'b001: begin
        alu_f3  = 3'b000;
        alu_sub = 1'b1;
      end
      3'b010: alu_f3 = 3'b111;
      3'b011: alu_f3 = 3'b110;
      3'b101: alu_f3 = 3'b010;
      default: alu_ok = 1'b0;
    endcase
  end

  // Assemble the instruction word for the requested format.
  always_comb begin
    legal = 1'b0;
    word  = 32'h0;
    case (kind)
      3'd0: begin
        legal = alu_ok;
        word  = {alu_sub ? 7'b0100000 : 7'b0000000,
                 rs2, rs1, alu_f3, rd, OPC_R};
      end
      3'd1: begin
        legal = alu_ok && !alu_sub;
        word  = {imm, rs1, alu_f3, rd, OPC_I};
      end
      3'd2: begin
        legal = 1'b1;
        word  = {imm, rs1, 3'b010, rd, OPC_LW};
      end
      3'd3: begin
        legal = 1'b1;
        word  = {imm[11:5], rs2, rs1, 3'b010,
                 imm[4:0], OPC_SW};
      end
      3'd4: begin
        legal = 1'b1;
        word  = {imm[11], imm[9:4], rs2, rs1, 3'b000,
                 imm[3:0], imm[10], OPC_BEQ};
      end
      default: begin
        legal = 1'b0;
        word  = 32'h0;
      end
    endcase
  end

  // Next-state: address counter, fill state and registered write port.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    if (restart) begin
      state_d = ST_LOADING;
      count_d = '0;
    end else if (fire) begin
      if (legal) begin
        wr_en_d   = 1'b1;
        wr_addr_d = BASE + count_q;
        wr_data_d = word;
        count_d   = count_q + 1'b1;
        if (count_q == '1) begin
          state_d = ST_FULL;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LOADING;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE;
      wr_data_q <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: a field-level reference model checked
// every cycle, plus literal encodings for known instructions.
module tb_instr_stream_encoder;

  localparam int AW   = 8;
  localparam int BASE = 0;
  localparam int SLOTS = 1 << AW;

  logic          clk;
  logic          rst;
  logic          restart;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    kind;
  logic [2:0]    alu_sel;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [11:0]   imm;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          err;
  logic          done;

  int errors = 0;
  int checks = 0;

  instr_stream_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .alu_sel(alu_sel),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .err(err), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: is the request legal, and what word does it encode to.
  function automatic bit m_legal(input int k, input int a);
    bit alu_def;
    alu_def = (a == 0) || (a == 1) || (a == 2) || (a == 3) || (a == 5);
    if (k == 0) return alu_def;
    if (k == 1) return alu_def && (a != 1);
    return (k >= 2) && (k <= 4);
  endfunction

  function automatic logic [31:0] m_enc(input int k, input int a,
      input int d, input int s1, input int s2, input int im);
    int f3;
    int f7;
    logic [31:0] w;
    f3 = 0;
    f7 = 0;
    if (a == 2) f3 = 7;
    if (a == 3) f3 = 6;
    if (a == 5) f3 = 2;
    if (a == 1) f7 = 32;
    w = 32'h0;
    case (k)
      0: w = 32'(f7 * (1 << 25) + s2 * (1 << 20) + s1 * (1 << 15)
                 + f3 * (1 << 12) + d * (1 << 7) + 51);
      1: w = 32'(im * (1 << 20) + s1 * (1 << 15)
                 + f3 * (1 << 12) + d * (1 << 7) + 19);
      2: w = 32'(im * (1 << 20) + s1 * (1 << 15)
                 + 2 * (1 << 12) + d * (1 << 7) + 3);
      3: w = 32'((im / 32) * (1 << 25) + s2 * (1 << 20)
                 + s1 * (1 << 15) + 2 * (1 << 12)
                 + (im % 32) * (1 << 7) + 35);
      4: w = 32'(((im / 2048) % 2) * (1 << 31)
                 + ((im / 16) % 64) * (1 << 25)
                 + s2 * (1 << 20) + s1 * (1 << 15)
                 + (im % 16) * (1 << 8)
                 + ((im / 1024) % 2) * (1 << 7) + 99);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  int          m_count;
  bit          m_full;
  bit          e_wen;
  bit          e_err;
  int          e_addr;
  logic [31:0] e_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count = 0;
      m_full  = 0;
      e_wen   = 0;
      e_err   = 0;
      e_addr  = BASE;
      e_data  = 32'h0;
    end else begin
      e_wen = 0;
      e_err = 0;
      if (restart) begin
        m_count = 0;
        m_full  = 0;
      end else if (in_valid && !m_full) begin
        if (m_legal(int'(kind), int'(alu_sel))) begin
          e_wen  = 1;
          e_addr = (BASE + m_count) % SLOTS;
          e_data = m_enc(int'(kind), int'(alu_sel), int'(rd),
                         int'(rs1), int'(rs2), int'(imm));
          if (m_count == SLOTS - 1) m_full = 1;
          m_count = (m_count + 1) % SLOTS;
        end else begin
          e_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m.wr_en", 32'(wr_en), 32'(e_wen));
    chk("m.err", 32'(err), 32'(e_err));
    chk("m.done", 32'(done), 32'(m_full));
    chk("m.in_ready", 32'(in_ready),
        32'(!m_full && !restart && !rst));
    if (e_wen || rst) begin
      chk("m.wr_addr", 32'(wr_addr), 32'(e_addr));
      chk("m.wr_data", wr_data, e_data);
    end
  end

  task automatic send(input int k, input int a, input int d,
      input int s1, input int s2, input int im);
    kind     = 3'(k);
    alu_sel  = 3'(a);
    rd       = 5'(d);
    rs1      = 5'(s1);
    rs2      = 5'(s2);
    imm      = 12'(im);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Checks on the cycle right after a send.
  task automatic expect_wr(input string name, input int addr,
                           input logic [31:0] data);
    @(negedge clk);
    chk({name, ".wen"}, 32'(wr_en), 32'd1);
    chk({name, ".addr"}, 32'(wr_addr), 32'(addr));
    chk({name, ".data"}, wr_data, data);
  endtask

  task automatic expect_err(input string name);
    @(negedge clk);
    chk({name, ".err"}, 32'(err), 32'd1);
    chk({name, ".wen"}, 32'(wr_en), 32'd0);
    @(negedge clk);
    chk({name, ".errgone"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    restart  = 1'b0;
    in_valid = 1'b0;
    kind     = '0;
    alu_sel  = '0;
    rd       = '0;
    rs1      = '0;
    rs2      = '0;
    imm      = '0;
    #2;
    chk("rst.wen", 32'(wr_en), 32'd0);
    chk("rst.addr", 32'(wr_addr), 32'(BASE));
    chk("rst.data", wr_data, 32'h0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd0);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(0, 0, 3, 1, 2, 0);
    expect_wr("add", 0, 32'h002081B3);
    send(0, 1, 5, 6, 7, 0);
    expect_wr("sub", 1, 32'h407302B3);
    send(1, 0, 1, 0, 0, 5);
    expect_wr("addi", 2, 32'h00500093);
    send(3, 0, 0, 1, 2, 8);
    expect_wr("sw", 3, 32'h0020A423);
    send(4, 0, 0, 1, 2, 12'hFFE);
    expect_wr("beq", 4, 32'hFE208EE3);
    send(2, 7, 9, 4, 31, 12'h7F0);
    expect_wr("lw", 5, 32'h7F022483);
    send(1, 5, 2, 3, 0, 12'h801);
    expect_wr("slti", 6, 32'h8011A113);

    send(1, 1, 1, 1, 1, 1);
    expect_err("isub");
    send(6, 0, 1, 1, 1, 1);
    expect_err("kind6");
    send(0, 4, 1, 1, 1, 1);
    expect_err("alu4");
    send(0, 2, 8, 9, 10, 0);
    expect_wr("after_err", 7, 32'h00A4F433);

    // Fill the remaining slots back to back.
    for (int i = 8; i < SLOTS; i++) begin
      send(i % 5, (i % 2) * 2, i % 32, (i / 2) % 32,
           (i / 3) % 32, (i * 37) % 4096);
    end
    @(negedge clk);
    chk("full.done", 32'(done), 32'd1);
    chk("full.ready", 32'(in_ready), 32'd0);
    send(0, 0, 3, 1, 2, 0);
    @(negedge clk);
    chk("full.nowr", 32'(wr_en), 32'd0);

    // Restart coincident with a request.
    restart  = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("rs.ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    restart  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rs.nowr", 32'(wr_en), 32'd0);
    chk("rs.done", 32'(done), 32'd0);
    send(0, 3, 4, 5, 6, 0);
    expect_wr("rs.first", 0, 32'h0062E233);

    // Async reset right after an accept.
    send(0, 0, 3, 1, 2, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.wen", 32'(wr_en), 32'd0);
    chk("arst.addr", 32'(wr_addr), 32'(BASE));
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(0, 0, 3, 1, 2, 0);
    expect_wr("arst.first", 0, 32'h002081B3);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
